// File: rtl/sobel_stream_lb.sv
// sobel_stream_lb: streaming 3x3 Sobel edge detector for raster-order pixels.
// Two line buffers hold the previous two input rows, so storage grows with
// IMG_W only. A 3x3 window of registers shifts one column per accepted pixel.
// Only interior pixels are emitted, one cycle after the input pixel that
// completes their neighbourhood.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_data is the raster-order pixel
//   mode            0 |Gx|+|Gy|, 1 threshold binary, 2 |Gx|, 3 |Gy|
//   threshold       compare level used in mode 1
//   out_valid/ready output handshake; out_data is the filtered pixel
//   out_eol         last output of an output row
//   out_last        last output of the frame
//   frame_done      one-cycle pulse after the out_last transfer
//   busy            high from the first accepted pixel until frame_done
module sobel_stream_lb #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 8,
  parameter int IMG_W = 30,
  parameter int IMG_H = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int SUM_W = PIX_W + 2;
  localparam int G_W   = PIX_W + 3;
  localparam int MAG_W = PIX_W + 4;
  localparam int CMP_W = (MAG_W > OUT_W) ? MAG_W : OUT_W;
  localparam logic [CMP_W-1:0] OUT_MAX  = CMP_W'({OUT_W{1'b1}});
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] nwin [3][3];
  logic [1:0]       mode_f;
  logic [OUT_W-1:0] thr_f;

  logic xfer, out_hs, produce, first_pix, col_end, row_end;

  logic [SUM_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [G_W-1:0]   gx, gy;
  logic [SUM_W-1:0]        abs_x, abs_y;
  logic [MAG_W-1:0]        sum_mag, sel_mag;
  logic [OUT_W-1:0]        result;

  assign in_ready  = !out_valid || out_ready;
  assign xfer      = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign col_end   = (col == COL_LAST);
  assign row_end   = (row == ROW_LAST);
  assign first_pix = (row == '0) && (col == '0);
  assign produce   = xfer && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // Window as it will look after this transfer; the output is computed from
  // it so the result can be registered on the same edge as the shift.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
    end
    nwin[0][2] = lb1[col];
    nwin[1][2] = lb0[col];
    nwin[2][2] = in_data;
  end

  assign gx_pos = SUM_W'(nwin[0][2]) + (SUM_W'(nwin[1][2]) << 1) + SUM_W'(nwin[2][2]);
  assign gx_neg = SUM_W'(nwin[0][0]) + (SUM_W'(nwin[1][0]) << 1) + SUM_W'(nwin[2][0]);
  assign gy_pos = SUM_W'(nwin[2][0]) + (SUM_W'(nwin[2][1]) << 1) + SUM_W'(nwin[2][2]);
  assign gy_neg = SUM_W'(nwin[0][0]) + (SUM_W'(nwin[0][1]) << 1) + SUM_W'(nwin[0][2]);

  assign gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  // |G| never exceeds 4*(2^PIX_W-1), so it fits back into SUM_W bits.
  assign abs_x = gx[G_W-1] ? SUM_W'(-gx) : SUM_W'(gx);
  assign abs_y = gy[G_W-1] ? SUM_W'(-gy) : SUM_W'(gy);
  assign sum_mag = MAG_W'(abs_x) + MAG_W'(abs_y);

  always_comb begin
    sel_mag = sum_mag;
    result  = '0;
    case (mode_f)
      2'd2:    sel_mag = MAG_W'(abs_x);
      2'd3:    sel_mag = MAG_W'(abs_y);
      default: sel_mag = sum_mag;
    endcase
    if (mode_f == 2'd1)
      result = (CMP_W'(sum_mag) >= CMP_W'(thr_f)) ? '1 : '0;
    else if (CMP_W'(sel_mag) > OUT_MAX)
      result = '1;
    else
      result = OUT_W'(sel_mag);
  end

  // Line buffers are never read before being rewritten, so no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      mode_f     <= '0;
      thr_f      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_eol    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      frame_done <= out_hs && out_last;

      if (xfer) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            win[r][c] <= nwin[r][c];
        if (first_pix) begin
          mode_f <= mode;
          thr_f  <= threshold;
        end
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_eol   <= col_end;
        out_last  <= col_end && row_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // The only pixel that can transfer alongside the out_last handshake is
      // (0,0) of the next frame, which keeps busy high.
      if (xfer)
        busy <= 1'b1;
      else if (out_hs && out_last)
        busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream_lb.sv
module tb_sobel_stream_lb;

  localparam int PIX_W = 8;
  localparam int OUT_W = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic [1:0]       mode;
  logic [OUT_W-1:0] threshold;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_eol;
  logic             out_last;
  logic             frame_done;
  logic             busy;

  sobel_stream_lb #(.PIX_W(PIX_W), .OUT_W(OUT_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .out_last(out_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    bit               eol;
    bit               last;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   got[$];
  int   pat [IMG_H][IMG_W];
  int   fr  [IMG_H][IMG_W];
  int   m_r, m_c, f_mode, f_thr;
  bit   exp_fd, exp_busy, stall_prev;
  logic [OUT_W-1:0] held_data;
  int   n_out, n_fd;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: direct Sobel on the stored frame, centre (r,c).
  function automatic exp_t ref_out(int r, int c);
    int gx, gy, ax, ay, mag;
    exp_t e;
    gx = (fr[r-1][c+1] + 2*fr[r][c+1] + fr[r+1][c+1])
       - (fr[r-1][c-1] + 2*fr[r][c-1] + fr[r+1][c-1]);
    gy = (fr[r+1][c-1] + 2*fr[r+1][c] + fr[r+1][c+1])
       - (fr[r-1][c-1] + 2*fr[r-1][c] + fr[r-1][c+1]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (f_mode)
      1:       mag = ((ax + ay) >= f_thr) ? 255 : 0;
      2:       mag = ax;
      3:       mag = ay;
      default: mag = ax + ay;
    endcase
    if (mag > 255) mag = 255;
    e.d    = OUT_W'(mag);
    e.eol  = (c == IMG_W - 2);
    e.last = (c == IMG_W - 2) && (r == IMG_H - 2);
    return e;
  endfunction

  task automatic model_accept(input int d, input int md, input int th);
    fr[m_r][m_c] = d;
    if (m_r == 0 && m_c == 0) begin
      f_mode = md;
      f_thr  = th;
    end
    if (m_r >= 2 && m_c >= 2) q.push_back(ref_out(m_r - 1, m_c - 1));
    if (m_c == IMG_W - 1) begin
      m_c = 0;
      m_r = (m_r == IMG_H - 1) ? 0 : m_r + 1;
    end else begin
      m_c++;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick(output bit acc);
    bit   hs;
    exp_t e;
    #1;
    chk(frame_done, exp_fd, "frame_done");
    chk(busy, exp_busy, "busy");
    chk(in_ready, !out_valid || out_ready, "in_ready");
    if (frame_done) n_fd++;
    if (stall_prev) begin
      chk(out_valid, 1, "hold_valid");
      chk(out_data, held_data, "hold_data");
    end
    hs = out_valid && out_ready;
    exp_fd = 0;
    if (hs) begin
      if (q.size() == 0) begin
        chk(out_valid, 0, "unexpected_output");
      end else begin
        e = q.pop_front();
        chk(out_data, e.d, "out_data");
        chk(out_eol, e.eol, "out_eol");
        chk(out_last, e.last, "out_last");
        got.push_back(int'(out_data));
        n_out++;
        if (e.last) exp_fd = 1;
      end
    end
    stall_prev = out_valid && !out_ready;
    held_data  = out_data;
    acc = in_valid && in_ready;
    if (acc) model_accept(int'(in_data), int'(mode), int'(threshold));
    if (acc) exp_busy = 1;
    else if (exp_fd) exp_busy = 0;
    @(negedge clk);
  endtask

  task automatic make_pat(input int kind, input int maxv);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (kind)
          0:       pat[r][c] = 100;
          1:       pat[r][c] = (c < 2) ? 0 : 10;
          2:       pat[r][c] = (c < 2) ? 0 : 255;
          default: pat[r][c] = $urandom_range(0, maxv);
        endcase
  endtask

  task automatic send_frame(input int md, input int th, input int mid_th, input int n_pix,
                            input bit bp, input int stall_idx);
    int idx = 0;
    int guard = 0;
    int stall_n = 0;
    bit acc;
    while (idx < n_pix && guard < 2000) begin
      in_valid  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = PIX_W'(pat[idx / IMG_W][idx % IMG_W]);
      mode      = (idx == 0) ? 2'(md) : 2'($urandom_range(0, 3));
      threshold = (idx == 0) ? OUT_W'(th) : OUT_W'(mid_th);
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (idx == stall_idx && stall_n < 3) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        stall_n++;
        #1;
        chk(in_ready, 0, "stall_in_ready");
        chk(out_valid, 1, "stall_out_valid");
      end
      tick(acc);
      if (acc) idx++;
      guard++;
    end
    chk(idx, n_pix, "send_progress");
  endtask

  task automatic drain();
    int g = 0;
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && g < 20) begin
      tick(acc);
      g++;
    end
    chk(q.size(), 0, "drain_empty");
    tick(acc);
    tick(acc);
  endtask

  task automatic clr_cnt();
    n_out = 0;
    n_fd  = 0;
    got.delete();
  endtask

  task automatic chk_seq(input int a, input int b, input int c, input string tag);
    int exp3[3];
    exp3[0] = a; exp3[1] = b; exp3[2] = c;
    chk(got.size(), 6, {tag, "_count"});
    for (int i = 0; i < got.size() && i < 6; i++)
      chk(got[i], exp3[i % 3], tag);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    chk(out_valid, 0, "rst_out_valid");
    chk(out_data, 0, "rst_out_data");
    chk(busy, 0, "rst_busy");
    chk(frame_done, 0, "rst_frame_done");
    q.delete();
    m_r = 0; m_c = 0;
    exp_fd = 0; exp_busy = 0; stall_prev = 0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; threshold = '0; out_ready = 1'b1;
    m_r = 0; m_c = 0; f_mode = 0; f_thr = 0;
    exp_fd = 0; exp_busy = 0; stall_prev = 0; held_data = '0;
    n_out = 0; n_fd = 0;
    repeat (2) @(negedge clk);
    #1;
    chk(out_valid, 0, "reset_out_valid");
    chk(out_data, 0, "reset_out_data");
    chk(out_eol, 0, "reset_out_eol");
    chk(out_last, 0, "reset_out_last");
    chk(frame_done, 0, "reset_frame_done");
    chk(busy, 0, "reset_busy");
    reset = 1'b1;
    @(negedge clk);

    // Flat frame
    make_pat(0, 0); clr_cnt();
    send_frame(0, 0, $urandom_range(0, 255), NPIX, 0, -1); drain();
    chk(n_out, 6, "const_n_out");
    chk(n_fd, 1, "const_n_fd");
    chk_seq(0, 0, 0, "const_vals");
    chk(busy, 0, "const_busy_idle");

    // Vertical edge in modes 0, 2, 3
    make_pat(1, 0);
    clr_cnt(); send_frame(0, 0, 0, NPIX, 0, -1); drain(); chk_seq(40, 40, 0, "edge_m0");
    clr_cnt(); send_frame(2, 0, 0, NPIX, 0, -1); drain(); chk_seq(40, 40, 0, "edge_m2");
    clr_cnt(); send_frame(3, 0, 0, NPIX, 0, -1); drain(); chk_seq(0, 0, 0, "edge_m3");

    // Saturation
    make_pat(2, 0);
    clr_cnt(); send_frame(0, 0, 0, NPIX, 0, -1); drain(); chk_seq(255, 255, 0, "sat_m0");

    // Threshold, including a mid-frame change that must be ignored
    make_pat(1, 0);
    clr_cnt(); send_frame(1, 40, 40, NPIX, 0, -1); drain(); chk_seq(255, 255, 0, "thr40");
    clr_cnt(); send_frame(1, 41, 41, NPIX, 0, -1); drain(); chk_seq(0, 0, 0, "thr41");
    clr_cnt(); send_frame(1, 40, 41, NPIX, 0, -1); drain(); chk_seq(255, 255, 0, "thr_mid");

    // Three-cycle output stall right after the first output appears
    clr_cnt(); send_frame(0, 0, 0, NPIX, 0, 13); drain(); chk_seq(40, 40, 0, "stall");

    // Abort after 9 pixels, then a full frame
    make_pat(3, 255);
    clr_cnt(); send_frame(0, 0, 0, 9, 0, -1); do_reset();
    send_frame(0, 0, 0, NPIX, 0, -1); drain();
    chk(n_out, 6, "abort9_n_out");
    chk(n_fd, 1, "abort9_n_fd");
    chk(busy, 0, "abort9_busy");

    // Abort with an output pending under back-pressure
    make_pat(3, 60);
    clr_cnt(); send_frame(2, 0, 0, 13, 0, -1);
    out_ready = 1'b0;
    do_reset();
    send_frame(3, 0, 0, NPIX, 0, -1); drain();
    chk(n_out, 6, "abort13_n_out");
    chk(n_fd, 1, "abort13_n_fd");

    // Back-to-back frames
    clr_cnt();
    make_pat(3, 80);  send_frame(0, 0, 0, NPIX, 0, -1);
    make_pat(3, 255); send_frame(1, 200, 10, NPIX, 0, -1);
    drain();
    chk(n_out, 12, "b2b_n_out");
    chk(n_fd, 2, "b2b_n_fd");
    chk(busy, 0, "b2b_busy");

    // Random frames with random gaps and back-pressure
    for (int f = 0; f < 8; f++) begin
      make_pat(3, (f % 2) ? 255 : 40);
      clr_cnt();
      send_frame($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), NPIX, 1, -1);
      drain();
      chk(n_out, 6, "rand_n_out");
      chk(n_fd, 1, "rand_n_fd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream_lb.md
Name: sobel_stream_lb

Overview:
Streaming 3x3 Sobel edge detector for raster-order pixel streams. It replaces the full-frame RAM approach with two line buffers, so storage is O(IMG_W) instead of O(IMG_W*IMG_H). Width, resolution and output mode are parametrised, and valid/ready handshakes are used on both sides. It sits between the pixel source (camera or memory reader) and the downstream frame writer.

Parameters:
PIX_W, 8, input pixel width in bits (unsigned)
OUT_W, 8, output pixel width in bits
IMG_W, 30, pixels per line (>= 3)
IMG_H, 30, lines per frame (>= 3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
in_data  in  PIX_W  input pixel, raster order, row 0 col 0 first
mode  in  2  0 = |Gx|+|Gy|, 1 = threshold binary, 2 = |Gx| only, 3 = |Gy| only
threshold  in  OUT_W  threshold used in mode 1
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts the output
out_data  out  OUT_W  filtered pixel
out_eol  out  1  marks the last output of an output row
out_last  out  1  marks the last output of the frame
frame_done  out  1  one-cycle pulse when the last output transfers
busy  out  1  high from the first accepted pixel until frame_done

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid, out_data, out_eol, out_last, frame_done and busy all clear to 0.
  - Row and column counters clear to 0.
  - Window registers clear to 0.
  - Line-buffer contents are not cleared. They are never consumed before being refilled.
- Input transfer: occurs on in_valid && in_ready.
- Back-pressure: in_ready = !out_valid || out_ready, a single-entry output register.
  - With in_valid=0, the block holds its state.
- Counters: col counts 0..IMG_W-1, row counts 0..IMG_H-1, advancing per transfer.
  - After (IMG_H-1, IMG_W-1) both wrap to 0 and the next frame starts with no gap.
- Line buffers: LB0 holds row r-1 and LB1 holds row r-2, both addressed by col.
  - On each transfer, at address col: LB1 <= LB0, LB0 <= in_data.
- Window: a 3x3 register shift, one column per transfer.
  - New right column = {LB1[col], LB0[col], in_data} (top to bottom).
- Output generation: only interior pixels are output, (IMG_W-2)*(IMG_H-2) per frame.
  - The transfer of input (r,c) with r >= 2 and c >= 2 produces output (r-1,c-1).
  - Output registers load on the clock edge of that transfer, so out_valid is high the next cycle. Latency is 1 cycle.
  - out_valid drops after the handshake unless a new output loads on the same edge.
  - out_data, out_eol and out_last stay stable while out_valid && !out_ready.
- Arithmetic, with window p[row][col], row 0 = top, col 0 = left:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), signed, PIX_W+3 bits.
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02), signed, PIX_W+3 bits.
  - mag = |Gx| + |Gy| (mode 0), |Gx| (mode 2) or |Gy| (mode 3), PIX_W+4 bits unsigned.
  - out_data = min(mag, 2^OUT_W - 1).
  - Mode 1: out_data = all-ones if mag >= threshold, otherwise 0. Here mag = |Gx|+|Gy| unsaturated.
- Mode and threshold are sampled at the transfer of pixel (0,0) and held for the whole frame. Changes mid-frame have no effect until the next frame.
- out_eol = 1 for output column IMG_W-2. out_last = 1 for output (IMG_H-2, IMG_W-2).
- frame_done pulses for one cycle on the out_last transfer. busy falls on the same edge, unless pixel (0,0) of the next frame transfers on that edge.
- Reset asserted mid-frame: the partial frame is discarded and any pending output is dropped. The next accepted pixel is treated as (0,0).

Test Plan:
- Params IMG_W=5, IMG_H=4, mode 0. Constant 100 frame, out_ready=1 -> exactly 6 outputs, all 0. out_eol on outputs 3 and 6, out_last and frame_done on output 6 only.
- Vertical edge, cols 0-1 = 0 and cols 2-4 = 10, mode 0 -> each output row 40,40,0. Mode 2 gives the same values; mode 3 gives 0,0,0.
- Saturation, cols 0-1 = 0 and cols 2-4 = 255, PIX_W=OUT_W=8, mode 0 -> Gx=1020, so outputs 255,255,0.
- Threshold, vertical edge frame, mode 1. threshold=40 -> 255,255,0 per row. threshold=41 -> 0,0,0. Threshold changed to 41 mid-frame -> the frame still uses 40.
- Back-pressure: hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, out_data stable, no pixel lost. Output sequence is identical to the free-running run.
- Reset pulse after 9 input pixels, then a full frame -> no output from the aborted frame. The next frame produces the correct 6 outputs and busy=0 after frame_done. Back-to-back frames without a gap -> 12 outputs and 2 frame_done pulses.
